mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one BRAM port (select/addr/data/rd/wr) between two requesters: port A (UART host controller)
//  and port B (on-fabric evaluation engine). Round-robin req/gnt arbitration with burst lock and a
//  fairness limit; returns 1-cycle-latency read data to the requester that issued the read.
//  Sits between both masters and the BRAM bank mux.
// PARAMETERS
//  MEM_SELECT_BITS  4   width of EBR block select
//  ADDR_BITS        8   BRAM word address width
//  DATA_BITS        16  BRAM word width
//  MAX_BURST        16  accesses an owner may make while the other port waits (unlocked); >=1
// PORTS
//  clk         in   1          system clock
//  resetn      in   1          asynchronous active-low reset
//  a_req/b_req in   1          requester wants the port; one access per cycle while granted and high
//  a_lock/b_lock in 1          owner keeps grant past MAX_BURST while high
//  a_wr/b_wr   in   1          1 = write, 0 = read, for the access in this cycle
//  a_sel/b_sel in   MEM_SELECT_BITS  target EBR
//  a_addr/b_addr in ADDR_BITS  word address
//  a_wdata/b_wdata in DATA_BITS write data
//  a_gnt/b_gnt out  1          registered grant; never both high
//  a_rvalid/b_rvalid out 1     read data valid, 1 cycle after granted read access
//  a_rdata/b_rdata out DATA_BITS read data (= mem_out when rvalid, else 0)
//  mem_select  out  MEM_SELECT_BITS  to BRAM mux
//  mem_addr    out  ADDR_BITS  to BRAM
//  write_data  out  DATA_BITS  to BRAM
//  rd_en/wr_en out  1          to BRAM; mutually exclusive
//  mem_out     in   DATA_BITS  BRAM read data, valid cycle after rd_en
//  owner       out  2          00 none, 01 A, 10 B (debug/LEDs)
// BEHAVIOUR
//  - Reset (async, resetn=0): state IDLE, all gnt/rvalid/rd_en/wr_en=0, mem_* and rdata=0,
//    owner=00, burst counter=0, round-robin pointer=A. Reset mid-burst aborts; no rvalid pending.
//  - FSM IDLE/OWN_A/OWN_B; gnt = (state==OWN_x). Request seen in cycle N -> gnt high in N+1.
//  - IDLE: only one req -> that owner; both -> port named by pointer; none -> stay.
//  - Access: in OWN_x cycle with x_req=1, mem_* driven combinationally from port x; wr_en=x_wr,
//    rd_en=~x_wr. No req or IDLE -> rd_en=wr_en=0, mem_* = 0.
//  - Read return: rvalid to issuing port one cycle after its read cycle, even if grant moved.
//  - Burst counter (clog2(MAX_BURST+1) bits): clears on ownership change, +1 per access, saturates.
//  - Leave OWN_x when: x_req=0 -> OWN_y if y_req else IDLE; or count==MAX_BURST and y_req and
//    x_lock=0 -> OWN_y. Lock holds grant indefinitely while x_req=1.
//  - Owner drops req same cycle other raises: other granted next cycle, no dead cycle.
//  - Pointer set to the other port on every grant; both req from IDLE alternates A,B,A...
//  - Requester must hold req/addr/wdata stable until it sees gnt; accesses before gnt are ignored.
// TESTING
//  1 reset: resetn=0 mid-burst of B reads -> all outputs 0 same cycle, no b_rvalid after release.
//  2 A alone: a_req=1 read addr 0x10 sel 3 -> a_gnt cycle 1, rd_en, a_rvalid cycle 2 with mem_out.
//  3 contention from IDLE: a_req,b_req same cycle -> A granted first, next contention from IDLE grants B.
//  4 fairness: A unlocked 40 accesses, b_req high -> after 16 A accesses b_gnt next cycle, then A.
//  5 lock: A locked 40 writes, b_req high -> A keeps grant all 40, B granted cycle after a_req drops.
//  6 handover read: A last read in cycle N, b_gnt cycle N+1 -> a_rvalid N+1, b_rvalid not set.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single BRAM port: round-robin from idle, burst fairness limit with
// an owner lock, and read data routed back to whichever port issued the read.
module mem_port_arbiter #(
  parameter int unsigned MEM_SELECT_BITS = 4,
  parameter int unsigned ADDR_BITS       = 8,
  parameter int unsigned DATA_BITS       = 16,
  parameter int unsigned MAX_BURST       = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       a_req,
  input  logic                       a_lock,
  input  logic                       a_wr,
  input  logic [MEM_SELECT_BITS-1:0] a_sel,
  input  logic [ADDR_BITS-1:0]       a_addr,
  input  logic [DATA_BITS-1:0]       a_wdata,
  output logic                       a_gnt,
  output logic                       a_rvalid,
  output logic [DATA_BITS-1:0]       a_rdata,
  input  logic                       b_req,
  input  logic                       b_lock,
  input  logic                       b_wr,
  input  logic [MEM_SELECT_BITS-1:0] b_sel,
  input  logic [ADDR_BITS-1:0]       b_addr,
  input  logic [DATA_BITS-1:0]       b_wdata,
  output logic                       b_gnt,
  output logic                       b_rvalid,
  output logic [DATA_BITS-1:0]       b_rdata,
  output logic [MEM_SELECT_BITS-1:0] mem_select,
  output logic [ADDR_BITS-1:0]       mem_addr,
  output logic [DATA_BITS-1:0]       write_data,
  output logic                       rd_en,
  output logic                       wr_en,
  input  logic [DATA_BITS-1:0]       mem_out,
  output logic [1:0]                 owner
);

  localparam int unsigned CntBits = $clog2(MAX_BURST + 1);
  localparam logic [CntBits-1:0] CntMax = CntBits'(MAX_BURST);

  // Encoding doubles as the owner debug output.
  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StOwnA = 2'b01;
  localparam logic [1:0] StOwnB = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [CntBits-1:0] cnt_q, cnt_d, cnt_inc;
  logic               ptr_q, ptr_d;  // 0: A wins the next contention from idle
  logic               a_rvalid_q, b_rvalid_q;
  logic               a_access, b_access, burst_done;

  assign a_gnt    = (state_q == StOwnA);
  assign b_gnt    = (state_q == StOwnB);
  assign a_access = a_gnt & a_req;
  assign b_access = b_gnt & b_req;
  assign owner    = state_q;

  assign cnt_inc    = (cnt_q == CntMax) ? cnt_q : cnt_q + CntBits'(1);
  // Includes the access being made this cycle, so the handover follows the last allowed access.
  assign burst_done = (cnt_inc == CntMax);

  always_comb begin
    mem_select = '0;
    mem_addr   = '0;
    write_data = '0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    if (a_access) begin
      mem_select = a_sel;
      mem_addr   = a_addr;
      write_data = a_wdata;
      wr_en      = a_wr;
      rd_en      = ~a_wr;
    end else if (b_access) begin
      mem_select = b_sel;
      mem_addr   = b_addr;
      write_data = b_wdata;
      wr_en      = b_wr;
      rd_en      = ~b_wr;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (a_req && (!b_req || !ptr_q)) begin
          state_d = StOwnA;
        end else if (b_req) begin
          state_d = StOwnB;
        end
      end
      StOwnA: begin
        if (!a_req) begin
          state_d = b_req ? StOwnB : StIdle;
        end else begin
          cnt_d = cnt_inc;
          if (burst_done && b_req && !a_lock) begin
            state_d = StOwnB;
          end
        end
      end
      StOwnB: begin
        if (!b_req) begin
          state_d = a_req ? StOwnA : StIdle;
        end else begin
          cnt_d = cnt_inc;
          if (burst_done && a_req && !b_lock) begin
            state_d = StOwnA;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == StOwnA) begin
        ptr_d = 1'b1;
      end else if (state_d == StOwnB) begin
        ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ptr_q      <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      a_rvalid_q <= a_access & ~a_wr;
      b_rvalid_q <= b_access & ~b_wr;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? mem_out : '0;
  assign b_rdata  = b_rvalid_q ? mem_out : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: cycle model of the arbitration rules, a BRAM model and
// a read-data scoreboard checked by an independent monitor.
module tb_mem_port_arbiter;

  localparam int SB = 4;
  localparam int AB = 8;
  localparam int DB = 16;
  localparam int MB = 16;
  localparam int MemWords = 1 << (SB + AB);

  typedef struct {
    int            due;
    logic [DB-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic          req_v[2];
  logic          lock_v[2];
  logic          wr_v[2];
  logic [SB-1:0] sel_v[2];
  logic [AB-1:0] addr_v[2];
  logic [DB-1:0] wdata_v[2];

  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, rd_en, wr_en;
  logic [DB-1:0] a_rdata, b_rdata, write_data, mem_out;
  logic [SB-1:0] mem_select;
  logic [AB-1:0] mem_addr;
  logic [1:0]    owner;

  logic [DB-1:0] bram[MemWords];
  logic [DB-1:0] shadow[MemWords];
  logic          filled = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   own, burst, ptr;
  bit   acc[2];
  int   rem[2];
  exp_t qa[$];
  exp_t qb[$];

  mem_port_arbiter #(
    .MEM_SELECT_BITS(SB),
    .ADDR_BITS      (AB),
    .DATA_BITS      (DB),
    .MAX_BURST      (MB)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .a_req     (req_v[0]),
    .a_lock    (lock_v[0]),
    .a_wr      (wr_v[0]),
    .a_sel     (sel_v[0]),
    .a_addr    (addr_v[0]),
    .a_wdata   (wdata_v[0]),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (req_v[1]),
    .b_lock    (lock_v[1]),
    .b_wr      (wr_v[1]),
    .b_sel     (sel_v[1]),
    .b_addr    (addr_v[1]),
    .b_wdata   (wdata_v[1]),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .mem_select(mem_select),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .mem_out   (mem_out),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM: write on wr_en, registered read; garbage on mem_out when no read was issued.
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < MemWords; i++) bram[i] <= DB'(i * 13);
      filled <= 1'b1;
    end else begin
      if (wr_en) bram[{mem_select, mem_addr}] <= write_data;
      mem_out <= rd_en ? bram[{mem_select, mem_addr}] : DB'($urandom);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " a_gnt"}, 32'(a_gnt), 0);
    chk({tag, " b_gnt"}, 32'(b_gnt), 0);
    chk({tag, " a_rvalid"}, 32'(a_rvalid), 0);
    chk({tag, " b_rvalid"}, 32'(b_rvalid), 0);
    chk({tag, " a_rdata"}, 32'(a_rdata), 0);
    chk({tag, " b_rdata"}, 32'(b_rdata), 0);
    chk({tag, " rd_en"}, 32'(rd_en), 0);
    chk({tag, " wr_en"}, 32'(wr_en), 0);
    chk({tag, " mem_select"}, 32'(mem_select), 0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 0);
    chk({tag, " write_data"}, 32'(write_data), 0);
    chk({tag, " owner"}, 32'(owner), 0);
  endtask

  // Reference: own 0 none / 1 A / 2 B, burst = accesses by current owner, ptr = port that wins
  // the next tie from idle.
  task automatic model_step();
    int p, x, y, nxt;
    logic [SB+AB-1:0] idx;
    if (!resetn) begin
      own = 0; burst = 0; ptr = 0; acc[0] = 0; acc[1] = 0;
      return;
    end
    chk("a_gnt", 32'(a_gnt), 32'(own == 1));
    chk("b_gnt", 32'(b_gnt), 32'(own == 2));
    chk("owner", 32'(owner), 32'(own));
    p = -1;
    if (own != 0 && req_v[own-1]) p = own - 1;
    acc[0] = (p == 0);
    acc[1] = (p == 1);
    if (p >= 0) begin
      idx = {sel_v[p], addr_v[p]};
      chk("rd_en", 32'(rd_en), 32'(!wr_v[p]));
      chk("wr_en", 32'(wr_en), 32'(wr_v[p]));
      chk("mem_select", 32'(mem_select), 32'(sel_v[p]));
      chk("mem_addr", 32'(mem_addr), 32'(addr_v[p]));
      chk("write_data", 32'(write_data), 32'(wdata_v[p]));
      if (wr_v[p]) shadow[idx] = wdata_v[p];
      else if (p == 0) qa.push_back('{cyc + 1, shadow[idx]});
      else qb.push_back('{cyc + 1, shadow[idx]});
    end else begin
      chk("idle rd_en", 32'(rd_en), 0);
      chk("idle wr_en", 32'(wr_en), 0);
      chk("idle mem_select", 32'(mem_select), 0);
      chk("idle mem_addr", 32'(mem_addr), 0);
      chk("idle write_data", 32'(write_data), 0);
    end
    if (own == 0) begin
      if (req_v[0] && req_v[1]) nxt = ptr + 1;
      else if (req_v[0]) nxt = 1;
      else if (req_v[1]) nxt = 2;
      else nxt = 0;
    end else begin
      x = own - 1;
      y = 1 - x;
      if (!req_v[x]) begin
        nxt = req_v[y] ? y + 1 : 0;
      end else begin
        if (burst < MB) burst++;
        nxt = (burst == MB && req_v[y] && !lock_v[x]) ? y + 1 : own;
      end
    end
    if (nxt != own) begin
      burst = 0;
      if (nxt != 0) ptr = 2 - nxt;
      own = nxt;
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  // Monitor: read data must arrive exactly one cycle after the read, on the issuing port only.
  initial forever begin
    @(negedge clk);
    if (resetn) begin
      for (int p = 0; p < 2; p++) begin
        logic          v;
        logic [DB-1:0] d;
        int            n;
        exp_t          f;
        v = (p == 0) ? a_rvalid : b_rvalid;
        d = (p == 0) ? a_rdata : b_rdata;
        n = (p == 0) ? qa.size() : qb.size();
        f = '{-1, '0};
        if (n > 0) f = (p == 0) ? qa[0] : qb[0];
        if (v) begin
          if (n == 0 || f.due != cyc) begin
            chk(p == 0 ? "a_rvalid unexpected" : "b_rvalid unexpected", 32'(v), 0);
          end else begin
            chk(p == 0 ? "a_rdata" : "b_rdata", 32'(d), 32'(f.data));
            if (p == 0) void'(qa.pop_front());
            else void'(qb.pop_front());
          end
        end else begin
          chk(p == 0 ? "a_rdata gated" : "b_rdata gated", 32'(d), 0);
          if (n > 0 && f.due <= cyc) begin
            chk(p == 0 ? "a_rvalid missing" : "b_rvalid missing", 32'(v), 1);
            if (p == 0) void'(qa.pop_front());
            else void'(qb.pop_front());
          end
        end
      end
    end
  end

  task automatic rand_access(input int p);
    wr_v[p]    = 1'($urandom_range(0, 1));
    sel_v[p]   = SB'($urandom_range(0, 3));
    addr_v[p]  = AB'($urandom_range(0, 19));
    wdata_v[p] = DB'($urandom);
  endtask

  // Requesters hold fields until granted; each granted cycle is one access.
  task automatic drive_cycle(input bit allow_start);
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (req_v[p] && acc[p]) begin
        rem[p]--;
        if (rem[p] == 0) req_v[p] = 1'b0;
        else rand_access(p);
      end
      if (!req_v[p] && allow_start && $urandom_range(0, 3) == 0) begin
        req_v[p]  = 1'b1;
        rem[p]    = $urandom_range(1, 40);
        lock_v[p] = ($urandom_range(0, 3) == 0);
        rand_access(p);
      end
    end
  endtask

  task automatic clear_stim();
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; lock_v[p] = 1'b0; wr_v[p] = 1'b0;
      sel_v[p] = '0; addr_v[p] = '0; wdata_v[p] = '0; rem[p] = 0;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < MemWords; i++) shadow[i] = DB'(i * 13);
    clear_stim();
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    repeat (3000) drive_cycle(1'b1);

    // Reset in the middle of a B burst.
    n = 0;
    while (n < 2000 && !(own == 2 && req_v[1])) begin
      drive_cycle(1'b1);
      n++;
    end
    chk("reached b burst", 32'(own == 2 && req_v[1]), 1);
    #2 resetn = 1'b0;
    #1 chk_all_zero("mid-burst reset");
    clear_stim();
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    repeat (3000) drive_cycle(1'b1);
    repeat (300) drive_cycle(1'b0);

    chk("a reads outstanding", 32'(qa.size()), 0);
    chk("b reads outstanding", 32'(qb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
